// File: rtl/sprite_fetcher.sv
// Sprite ROM requester: walks a sprite's ROM addresses row-major, tags each read with its screen
// coordinate and streams returned pixels downstream. Optional macro SPRITE_FETCHER_TRANSPARENCY_EN drops colour-keyed words.
module sprite_fetcher #(
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
`ifdef SPRITE_FETCHER_TRANSPARENCY_EN
    , parameter logic [15:0] TRANSPARENT_COLOUR = 16'hF81F
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  spriteId,
    input  logic [7:0]  originX,
    input  logic [8:0]  originY,
    input  logic [7:0]  spriteWidth,
    input  logic [8:0]  spriteHeight,
    output logic        busy,
    output logic        done,
    output logic [3:0]  ROMId,
    output logic [15:0] ROMAddr,
    input  logic [15:0] ReadROMOut,
    output logic        pixelValid,
    input  logic        pixelReady,
    output logic [7:0]  pixelX,
    output logic [8:0]  pixelY,
    output logic [15:0] pixelData
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_SLOT = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    state_t state_q, state_d;

    logic [3:0]  id_q, id_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  col_q, col_d, ox_q, ox_d, w_q, w_d;
    logic [8:0]  row_q, row_d, oy_q, oy_d, h_q, h_d;

    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [7:0] pipe_x_q [READ_LATENCY];
    logic [7:0] pipe_x_d [READ_LATENCY];
    logic [8:0] pipe_y_q [READ_LATENCY];
    logic [8:0] pipe_y_d [READ_LATENCY];

    logic [7:0]  buf_x_q [FIFO_DEPTH];
    logic [7:0]  buf_x_d [FIFO_DEPTH];
    logic [8:0]  buf_y_q [FIFO_DEPTH];
    logic [8:0]  buf_y_d [FIFO_DEPTH];
    logic [15:0] buf_d_q [FIFO_DEPTH];
    logic [15:0] buf_d_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d, inflight;

    logic start_ok, zero_size, last_pos, issue, push_raw, push, pop;

    always_comb begin
        start_ok  = start && (state_q == S_IDLE);
        zero_size = (spriteWidth == 8'd0) || (spriteHeight == 9'd0);
        last_pos  = (col_q == w_q - 8'd1) && (row_q == h_q - 9'd1);
        inflight  = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_vld_q[i]);
        end
        // Credit check: every read already committed must still find a buffer slot.
        issue    = (state_q == S_FETCH) && ((occ_q + inflight) < DEPTH_C);
        push_raw = pipe_vld_q[READ_LATENCY-1];
`ifdef SPRITE_FETCHER_TRANSPARENCY_EN
        push     = push_raw && (ReadROMOut != TRANSPARENT_COLOUR);
`else
        push     = push_raw;
`endif
        pop      = (occ_q != '0) && pixelReady;
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = zero_size ? S_DONE : S_FETCH;
            S_FETCH: if (issue && last_pos) state_d = S_DRAIN;
            S_DRAIN: if ((inflight == '0) && (occ_q == '0)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        ROMId      = id_q;
        ROMAddr    = addr_q;
        pixelValid = (occ_q != '0);
        pixelX     = '0;
        pixelY     = '0;
        pixelData  = '0;
        if (pixelValid) begin
            pixelX    = buf_x_q[rd_ptr_q];
            pixelY    = buf_y_q[rd_ptr_q];
            pixelData = buf_d_q[rd_ptr_q];
        end
    end

    // Address walk and draw parameter capture
    always_comb begin
        id_d   = id_q;
        addr_d = addr_q;
        col_d  = col_q;
        row_d  = row_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        w_d    = w_q;
        h_d    = h_q;
        if (start_ok && !zero_size) begin
            id_d   = spriteId;
            addr_d = '0;
            col_d  = '0;
            row_d  = '0;
            ox_d   = originX;
            oy_d   = originY;
            w_d    = spriteWidth;
            h_d    = spriteHeight;
        end
        if (issue && !last_pos) begin
            addr_d = addr_q + 16'd1;
            if (col_q == w_q - 8'd1) begin
                col_d = '0;
                row_d = row_q + 9'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    // Tag pipeline, aligned so the last stage meets the matching ROM word
    always_comb begin
        pipe_vld_d[0] = issue;
        pipe_x_d[0]   = ox_q + col_q;
        pipe_y_d[0]   = oy_q + row_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_x_d[i]   = pipe_x_q[i-1];
            pipe_y_d[i]   = pipe_y_q[i-1];
        end
    end

    // Return buffer
    always_comb begin
        buf_x_d  = buf_x_q;
        buf_y_d  = buf_y_q;
        buf_d_d  = buf_d_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            buf_x_d[wr_ptr_q] = pipe_x_q[READ_LATENCY-1];
            buf_y_d[wr_ptr_q] = pipe_y_q[READ_LATENCY-1];
            buf_d_d[wr_ptr_q] = ReadROMOut;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        occ_d = occ_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            id_q       <= '0;
            addr_q     <= '0;
            pipe_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            id_q       <= id_d;
            addr_q     <= addr_d;
            pipe_vld_q <= pipe_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
        col_q    <= col_d;
        row_q    <= row_d;
        ox_q     <= ox_d;
        oy_q     <= oy_d;
        w_q      <= w_d;
        h_q      <= h_d;
        pipe_x_q <= pipe_x_d;
        pipe_y_q <= pipe_y_d;
        buf_x_q  <= buf_x_d;
        buf_y_q  <= buf_y_d;
        buf_d_q  <= buf_d_d;
    end

endmodule

// File: tb/tb_sprite_fetcher.sv
// Bench for sprite_fetcher: two-cycle ROM model, expected-pixel queue built from the sprite geometry,
// directed and randomized draws under assorted pixelReady patterns.
module tb_sprite_fetcher;

    logic        clk = 1'b0;
    logic        reset, start, pixelReady;
    logic [3:0]  spriteId;
    logic [7:0]  originX, spriteWidth;
    logic [8:0]  originY, spriteHeight;
    logic        busy, done, pixelValid;
    logic [3:0]  ROMId;
    logic [15:0] ROMAddr, ReadROMOut, rom_s1, pixelData;
    logic [7:0]  pixelX;
    logic [8:0]  pixelY;

    typedef struct {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
    } pix_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   acc_cnt  = 0;
    bit   key_en   = 1'b0;
    bit   held     = 1'b0;
    pix_t held_p;
    pix_t exp_q[$];

    always #5 clk = ~clk;

    sprite_fetcher dut (
        .clock(clk), .reset(reset), .start(start), .spriteId(spriteId),
        .originX(originX), .originY(originY), .spriteWidth(spriteWidth),
        .spriteHeight(spriteHeight), .busy(busy), .done(done), .ROMId(ROMId),
        .ROMAddr(ROMAddr), .ReadROMOut(ReadROMOut), .pixelValid(pixelValid),
        .pixelReady(pixelReady), .pixelX(pixelX), .pixelY(pixelY), .pixelData(pixelData)
    );

    function automatic logic [15:0] rom_word(input logic [3:0] id, input logic [15:0] a);
        if (key_en && a == 16'd1) return 16'hF81F;
        return (a + 16'h1000) ^ {id ^ 4'd5, 12'h000};
    endfunction

    // ROM register followed by mux register
    always @(posedge clk) begin
        rom_s1     <= rom_word(ROMId, ROMAddr);
        ReadROMOut <= rom_s1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", pixelValid, 1);
                chk("hold_x", pixelX, held_p.x);
                chk("hold_y", pixelY, held_p.y);
                chk("hold_data", pixelData, held_p.d);
            end
            if (pixelValid && pixelReady) begin
                chk("pixel_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    pix_t e;
                    e = exp_q.pop_front();
                    chk("pixel_x", pixelX, e.x);
                    chk("pixel_y", pixelY, e.y);
                    chk("pixel_data", pixelData, e.d);
                end
                acc_cnt++;
            end
            held     = pixelValid && !pixelReady;
            held_p.x = pixelX;
            held_p.y = pixelY;
            held_p.d = pixelData;
        end
    end

    task automatic build(input logic [3:0] id, input logic [7:0] ox, input logic [8:0] oy,
                         input logic [7:0] w, input logic [8:0] h);
        exp_q.delete();
        for (int r = 0; r < int'(h); r++) begin
            for (int c = 0; c < int'(w); c++) begin
                pix_t p;
                p.x = 8'((int'(ox) + c) % 256);
                p.y = 9'((int'(oy) + r) % 512);
                p.d = rom_word(id, 16'(r * int'(w) + c));
`ifdef SPRITE_FETCHER_TRANSPARENCY_EN
                if (p.d == 16'hF81F) continue;
`endif
                exp_q.push_back(p);
            end
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic scramble_inputs();
        spriteId     = 4'($urandom);
        originX      = 8'($urandom);
        originY      = 9'($urandom);
        spriteWidth  = 8'($urandom);
        spriteHeight = 9'($urandom);
    endtask

    task automatic draw(input logic [3:0] id, input logic [7:0] ox, input logic [8:0] oy,
                        input logic [7:0] w, input logic [8:0] h, input int mode,
                        input int exp_done, input bit poke);
        int first_v, done_k;
        bit addr_moved, nonzero;
        logic [15:0] addr0;
        nonzero = (w != 0) && (h != 0);
        build(id, ox, oy, w, h);
        @(posedge clk); #1;
        start = 1'b1; spriteId = id; originX = ox; originY = oy;
        spriteWidth = w; spriteHeight = h; pixelReady = ready_for(mode, 0);
        addr0 = ROMAddr;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_inputs();
        first_v = -1; done_k = -1; addr_moved = 1'b0;
        for (int k = 1; k <= 600 && done_k < 0; k++) begin
            pixelReady = ready_for(mode, k);
            start = poke && (k == 5);
            @(negedge clk);
            if (k == 1) begin
                chk("busy_after_start", busy, 1);
                if (nonzero) begin
                    chk("first_addr", ROMAddr, 0);
                    chk("rom_id", ROMId, id);
                end
            end
            if (pixelValid && first_v < 0) first_v = k;
            if (ROMAddr !== addr0) addr_moved = 1'b1;
            if (done) done_k = k;
            else begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        chk("done_seen", done_k > 0, 1);
        if (exp_done > 0) chk("done_cycle", done_k, exp_done);
        if (nonzero) chk("first_valid_latency", first_v, 4);
        else begin
            chk("zero_addr_still", addr_moved, 0);
            chk("zero_no_valid", first_v, -1);
        end
        chk("all_pixels_seen", exp_q.size(), 0);
        @(posedge clk); #1;
        pixelReady = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_valid"}, pixelValid, 0);
        chk({pfx, "_romid"}, ROMId, 0);
        chk({pfx, "_romaddr"}, ROMAddr, 0);
        chk({pfx, "_x"}, pixelX, 0);
        chk({pfx, "_y"}, pixelY, 0);
        chk({pfx, "_data"}, pixelData, 0);
    endtask

    initial begin
        int w, h, m;
        reset = 1'b1; start = 1'b0; pixelReady = 1'b0;
        scramble_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Basic draw, with an ignored start while busy
        draw(4'd5, 8'd10, 9'd20, 8'd4, 9'd2, 0, 13, 1'b1);
        // Backpressure 1,0,0,...
        draw(4'd5, 8'd10, 9'd20, 8'd4, 9'd2, 1, -1, 1'b0);
        // Zero-size sprites
        draw(4'd3, 8'd40, 9'd50, 8'd0, 9'd3, 0, 1, 1'b0);
        draw(4'd3, 8'd40, 9'd50, 8'd3, 9'd0, 0, 1, 1'b0);
        // Coordinate wrap in X and Y
        draw(4'd2, 8'd254, 9'd100, 8'd4, 9'd1, 0, 9, 1'b0);
        draw(4'd7, 8'd5, 9'd510, 8'd2, 9'd3, 2, -1, 1'b0);
        draw(4'd1, 8'd0, 9'd0, 8'd1, 9'd1, 0, 6, 1'b0);

        // Reset at the third pixel
        build(4'd5, 8'd10, 9'd20, 8'd4, 9'd2);
        acc_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; spriteId = 4'd5; originX = 8'd10; originY = 9'd20;
        spriteWidth = 8'd4; spriteHeight = 9'd2; pixelReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (acc_cnt >= 2) break;
            @(posedge clk); #1;
        end
        chk("reached_third_pixel", acc_cnt >= 2, 1);
        @(posedge clk); #1;
        reset = 1'b1; pixelReady = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        reset = 1'b0;
        exp_q.delete();
        draw(4'd5, 8'd10, 9'd20, 8'd4, 9'd2, 0, 13, 1'b0);

        // Colour key at address 1
        key_en = 1'b1;
`ifdef SPRITE_FETCHER_TRANSPARENCY_EN
        draw(4'd5, 8'd0, 9'd0, 8'd2, 9'd2, 0, -1, 1'b0);
`else
        draw(4'd5, 8'd0, 9'd0, 8'd2, 9'd2, 0, 9, 1'b0);
`endif
        key_en = 1'b0;

        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 5);
            m = $urandom_range(0, 2);
            draw(4'($urandom), 8'($urandom), 9'($urandom), 8'(w), 9'(h), m,
                 (m == 0) ? w * h + 5 : -1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
